// File: rtl/demux1to2_stream_ctrl.sv
// Steers one valid/ready stream of WIDTH-bit words to channel A or B (by C, or alternating when MODE=1).
// One cycle from accept to valid output; X_ready drops while the target channel is full and its consumer is not ready.
module demux1to2_stream_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic             X_valid,
  output logic             X_ready,
  input  logic             C,
  input  logic             MODE,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [CNT_W-1:0] A_count,
  output logic [CNT_W-1:0] B_count,
  output logic             ptr
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_state_t;

  ptr_state_t state;
  ptr_state_t state_nxt;

  logic tgt;
  logic free_a;
  logic free_b;
  logic accept;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // A channel is free when it is empty or its held word leaves this cycle.
  assign free_a  = ~A_valid | A_ready;
  assign free_b  = ~B_valid | B_ready;
  assign tgt     = MODE ? ptr : C;
  assign X_ready = tgt ? free_b : free_a;
  assign accept  = X_valid & X_ready;
  assign load_a  = accept & ~tgt;
  assign load_b  = accept & tgt;
  assign drain_a = A_valid & A_ready;
  assign drain_b = B_valid & B_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PTR_A;
    end else begin
      state <= state_nxt;
    end
  end

  // No skipping: a stalled target keeps the pointer where it is.
  always_comb begin
    state_nxt = state;
    if (!MODE) begin
      state_nxt = PTR_A;
    end else if (accept) begin
      state_nxt = (state == PTR_A) ? PTR_B : PTR_A;
    end
  end

  always_comb begin
    ptr = (state == PTR_B);
  end

  // A load wins over a drain, so a same-cycle drain+load keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A       <= '0;
      A_valid <= 1'b0;
    end else if (load_a) begin
      A       <= X;
      A_valid <= 1'b1;
    end else if (drain_a) begin
      A_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      B       <= '0;
      B_valid <= 1'b0;
    end else if (load_b) begin
      B       <= X;
      B_valid <= 1'b1;
    end else if (drain_b) begin
      B_valid <= 1'b0;
    end
  end

  // Delivery counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A_count <= '0;
      B_count <= '0;
    end else begin
      if (drain_a) A_count <= A_count + CNT_W'(1);
      if (drain_b) B_count <= B_count + CNT_W'(1);
    end
  end

endmodule
